// File: rtl/maze_solver_param.sv
// Iterative depth-first maze search over a 1-bit cell RAM.
// Run-time start/goal, bounds skip, overflow fail, path replay.
module maze_solver_param #(
  parameter int COORD_W     = 4,
  parameter int MAX_X       = 15,
  parameter int MAX_Y       = 15,
  parameter int STACK_DEPTH = 256,
  parameter int SP_W        = 9
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               Start,
  input  logic               Run,
  input  logic [COORD_W-1:0] start_x,
  input  logic [COORD_W-1:0] start_y,
  input  logic [COORD_W-1:0] goal_x,
  input  logic [COORD_W-1:0] goal_y,
  input  logic               D_out,
  output logic               D_in,
  output logic               RD,
  output logic               WR,
  output logic [COORD_W-1:0] addr_x,
  output logic [COORD_W-1:0] addr_y,
  output logic [COORD_W-1:0] X,
  output logic [COORD_W-1:0] Y,
  output logic [1:0]         Move,
  output logic               Move_valid,
  output logic [SP_W-1:0]    path_len,
  output logic               Done,
  output logic               Fail
);

  localparam int AW =
    (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [COORD_W-1:0] XM = COORD_W'(MAX_X);
  localparam logic [COORD_W-1:0] YM = COORD_W'(MAX_Y);
  localparam logic [SP_W-1:0] SP_MAX = SP_W'(STACK_DEPTH);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_MARK   = 4'd1;
  localparam logic [3:0] S_TRY    = 4'd2;
  localparam logic [3:0] S_READ   = 4'd3;
  localparam logic [3:0] S_EVAL   = 4'd4;
  localparam logic [3:0] S_BACK   = 4'd5;
  localparam logic [3:0] S_DONE   = 4'd6;
  localparam logic [3:0] S_FAIL   = 4'd7;
  localparam logic [3:0] S_REPLAY = 4'd8;

  logic [3:0]         state;
  logic [COORD_W-1:0] pos_x, pos_y;
  logic [COORD_W-1:0] gx_q, gy_q;
  logic [2:0]         dir;
  logic [SP_W-1:0]    sp, ri, sp_m1;
  logic [1:0]         stack [STACK_DEPTH];

  logic [COORD_W-1:0] nb_x, nb_y, bk_x, bk_y;
  logic               nb_ok, push, restart;
  logic [1:0]         pop_d;

  assign sp_m1 = sp - 1'b1;
  assign pop_d = stack[sp_m1[AW-1:0]];

  // Neighbour in direction dir; nb_ok is false off-grid or dir==4
  always_comb begin
    nb_x  = pos_x;
    nb_y  = pos_y;
    nb_ok = 1'b0;
    case (dir)
      3'd0: begin
        nb_x  = pos_x + 1'b1;
        nb_ok = pos_x < XM;
      end
      3'd1: begin
        nb_y  = pos_y - 1'b1;
        nb_ok = pos_y != '0;
      end
      3'd2: begin
        nb_x  = pos_x - 1'b1;
        nb_ok = pos_x != '0;
      end
      3'd3: begin
        nb_y  = pos_y + 1'b1;
        nb_ok = pos_y < YM;
      end
      default: nb_ok = 1'b0;
    endcase
  end

  always_comb begin
    bk_x = pos_x;
    bk_y = pos_y;
    case (pop_d)
      2'd0:    bk_x = pos_x - 1'b1;
      2'd1:    bk_y = pos_y + 1'b1;
      2'd2:    bk_x = pos_x + 1'b1;
      default: bk_y = pos_y - 1'b1;
    endcase
  end

  assign restart = Start &&
    (state == S_IDLE || state == S_DONE ||
     state == S_FAIL);
  assign push = (state == S_EVAL) && !D_out &&
    (sp != SP_MAX);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      pos_x <= '0;
      pos_y <= '0;
      gx_q  <= '0;
      gy_q  <= '0;
      dir   <= '0;
      sp    <= '0;
      ri    <= '0;
    end else if (restart) begin
      pos_x <= start_x;
      pos_y <= start_y;
      gx_q  <= goal_x;
      gy_q  <= goal_y;
      sp    <= '0;
      state <= (start_x == goal_x && start_y == goal_y)
        ? S_DONE : S_MARK;
    end else begin
      case (state)
        S_MARK: begin
          dir   <= '0;
          state <= S_TRY;
        end
        S_TRY: begin
          if (dir == 3'd4) state <= S_BACK;
          else if (nb_ok)  state <= S_READ;
          else             dir   <= dir + 3'd1;
        end
        S_READ: state <= S_EVAL;
        S_EVAL: begin
          if (D_out) begin
            dir   <= dir + 3'd1;
            state <= S_TRY;
          end else if (sp == SP_MAX) begin
            state <= S_FAIL;
          end else begin
            sp    <= sp + 1'b1;
            pos_x <= nb_x;
            pos_y <= nb_y;
            state <= (nb_x == gx_q && nb_y == gy_q)
              ? S_DONE : S_MARK;
          end
        end
        S_BACK: begin
          if (sp == '0) begin
            state <= S_FAIL;
          end else begin
            sp    <= sp_m1;
            pos_x <= bk_x;
            pos_y <= bk_y;
            dir   <= {1'b0, pop_d} + 3'd1;
            state <= S_TRY;
          end
        end
        S_DONE: begin
          if (Run && sp != '0) begin
            ri    <= '0;
            state <= S_REPLAY;
          end
        end
        S_REPLAY: begin
          if (Run) begin
            ri <= ri + 1'b1;
            if (ri == sp_m1) state <= S_DONE;
          end
        end
        default: state <= state;
      endcase
    end
  end

  // Path storage kept reset-free so it can map onto RAM
  always_ff @(posedge CLK) begin
    if (push) stack[sp[AW-1:0]] <= dir[1:0];
  end

  assign WR         = (state == S_MARK);
  assign RD         = (state == S_READ);
  assign D_in       = WR;
  assign X          = pos_x;
  assign Y          = pos_y;
  assign path_len   = sp;
  assign Done       = (state == S_DONE) ||
                      (state == S_REPLAY);
  assign Fail       = (state == S_FAIL);
  assign Move_valid = (state == S_REPLAY) && Run;
  assign Move       = Move_valid ? stack[ri[AW-1:0]] : 2'd0;

  always_comb begin
    addr_x = '0;
    addr_y = '0;
    unique case (1'b1)
      WR: begin
        addr_x = pos_x;
        addr_y = pos_y;
      end
      RD: begin
        addr_x = nb_x;
        addr_y = nb_y;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_maze_solver_param.sv
// Scoreboard bench for maze_solver_param: directed mazes,
// queued expected results/moves/writes checked by monitors.
module tb_maze_solver_param;

  typedef struct packed {
    logic       done;
    logic       fail;
    logic [8:0] len;
    logic [3:0] x;
    logic [3:0] y;
  } res_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic [3:0] sx = '0, sy = '0, gx = '0, gy = '0;
  logic start_a = 1'b0, run_a = 1'b0;
  logic start_b = 1'b0, run_b = 1'b0;

  logic       d_out_a, d_in_a, rd_a, wr_a;
  logic [3:0] ax_a, ay_a, x_a, y_a;
  logic [1:0] mv_a;
  logic       mvv_a, done_a, fail_a;
  logic [8:0] len_a;

  logic       d_out_b, d_in_b, rd_b, wr_b;
  logic [3:0] ax_b, ay_b, x_b, y_b;
  logic [1:0] mv_b;
  logic       mvv_b, done_b, fail_b;
  logic [2:0] len_b;

  maze_solver_param dut_a (
    .CLK(CLK), .RST(RST), .Start(start_a), .Run(run_a),
    .start_x(sx), .start_y(sy),
    .goal_x(gx), .goal_y(gy),
    .D_out(d_out_a), .D_in(d_in_a),
    .RD(rd_a), .WR(wr_a),
    .addr_x(ax_a), .addr_y(ay_a),
    .X(x_a), .Y(y_a),
    .Move(mv_a), .Move_valid(mvv_a),
    .path_len(len_a), .Done(done_a), .Fail(fail_a)
  );

  maze_solver_param #(
    .STACK_DEPTH(4), .SP_W(3)
  ) dut_b (
    .CLK(CLK), .RST(RST), .Start(start_b), .Run(run_b),
    .start_x(sx), .start_y(sy),
    .goal_x(gx), .goal_y(gy),
    .D_out(d_out_b), .D_in(d_in_b),
    .RD(rd_b), .WR(wr_b),
    .addr_x(ax_b), .addr_y(ay_b),
    .X(x_b), .Y(y_b),
    .Move(mv_b), .Move_valid(mvv_b),
    .path_len(len_b), .Done(done_b), .Fail(fail_b)
  );

  logic mem_a [16][16];
  logic mem_b [16][16];
  logic clr = 1'b0, ld = 1'b0;
  logic [3:0] ld_x = '0, ld_y = '0;

  always @(posedge CLK) begin
    if (clr) begin
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < 16; j++) begin
          mem_a[i][j] <= 1'b0;
          mem_b[i][j] <= 1'b0;
        end
    end else begin
      if (ld) mem_a[ld_x][ld_y] <= 1'b1;
      if (wr_a) mem_a[ax_a][ay_a] <= d_in_a;
      if (wr_b) mem_b[ax_b][ay_b] <= d_in_b;
    end
    d_out_a <= rd_a ? mem_a[ax_a][ay_a] : 1'b0;
    d_out_b <= rd_b ? mem_b[ax_b][ay_b] : 1'b0;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int rd_cnt  = 0;
  logic wr_chk = 1'b0;

  res_t       exp_res[$];
  res_t       exp_res_b[$];
  logic [1:0] exp_mv[$];
  logic [7:0] exp_wr[$];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic res_t mk(input logic d, input logic f,
                              input int l, input int x,
                              input int y);
    res_t r;
    r.done = d;
    r.fail = f;
    r.len  = 9'(l);
    r.x    = 4'(x);
    r.y    = 4'(y);
    return r;
  endfunction

  // Result monitor for dut_a: fires on Done or Fail rising
  initial begin
    logic pd, pf;
    pd = 1'b0;
    pf = 1'b0;
    forever begin
      @(negedge CLK);
      if ((done_a && !pd) || (fail_a && !pf)) begin
        if (exp_res.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL result_extra: got %0h expected none",
                   {done_a, fail_a, len_a, x_a, y_a});
        end else begin
          check("result_a", {done_a, fail_a, len_a, x_a, y_a},
                exp_res.pop_front());
        end
      end
      pd = done_a;
      pf = fail_a;
    end
  end

  initial begin
    logic pd, pf;
    pd = 1'b0;
    pf = 1'b0;
    forever begin
      @(negedge CLK);
      if ((done_b && !pd) || (fail_b && !pf)) begin
        if (exp_res_b.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL result_b_extra: got %0h expected none",
                   {done_b, fail_b, len_b, x_b, y_b});
        end else begin
          check("result_b",
                {done_b, fail_b, 6'd0, len_b, x_b, y_b},
                exp_res_b.pop_front());
        end
      end
      pd = done_b;
      pf = fail_b;
    end
  end

  // Move, write and read-strobe monitors
  initial begin
    forever begin
      @(negedge CLK);
      if (mvv_a) begin
        if (exp_mv.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL move_extra: got %0d expected none",
                   mv_a);
        end else begin
          check("move", mv_a, exp_mv.pop_front());
        end
      end
      if (wr_a && wr_chk) begin
        if (exp_wr.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL write_extra: got %0h expected none",
                   {ax_a, ay_a});
        end else begin
          check("write_addr", {ax_a, ay_a},
                exp_wr.pop_front());
        end
      end
      if (rd_a) rd_cnt++;
      if ((rd_a && wr_a) || (rd_b && wr_b) || mvv_b) begin
        n_fail++;
        $display("FAIL strobe_rule: rd/wr overlap or b move");
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_maze();
    @(posedge CLK);
    #1 clr = 1'b1;
    @(posedge CLK);
    #1 clr = 1'b0;
  endtask

  task automatic wall(input int x, input int y);
    @(posedge CLK);
    #1 ld = 1'b1;
    ld_x = 4'(x);
    ld_y = 4'(y);
    @(posedge CLK);
    #1 ld = 1'b0;
  endtask

  task automatic go(input bit b, input int x0, input int y0,
                    input int x1, input int y1);
    @(posedge CLK);
    #1;
    sx = 4'(x0);
    sy = 4'(y0);
    gx = 4'(x1);
    gy = 4'(y1);
    if (b) start_b = 1'b1;
    else   start_a = 1'b1;
    @(posedge CLK);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_end(input bit b, output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(b ? (done_b || fail_b) : (done_a || fail_a))
               && n < 3000);
    if (n >= 3000) begin
      n_tests++;
      n_fail++;
      $display("FAIL end_timeout: got none expected done/fail");
    end
  endtask

  task automatic replay(input string name, input int cnt);
    @(posedge CLK);
    #1 run_a = 1'b1;
    @(posedge CLK);
    repeat (cnt) begin
      @(negedge CLK);
      check({name, "_valid"}, mvv_a, 1'b1);
    end
    @(negedge CLK);
    check({name, "_end"}, mvv_a, 1'b0);
    run_a = 1'b0;
  endtask

  initial begin
    int n, base, k;
    logic rp [5];
    rp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    clear_maze();
    @(negedge CLK);
    check("reset_outs_a",
          {d_in_a, rd_a, wr_a, ax_a, ay_a, x_a, y_a,
           mv_a, mvv_a, len_a, done_a, fail_a}, '0);
    check("reset_outs_b",
          {d_in_b, rd_b, wr_b, x_b, y_b, len_b,
           done_b, fail_b}, '0);
    RST = 1'b0;

    // straight corridor along y=0
    exp_wr.push_back({4'd0, 4'd0});
    exp_wr.push_back({4'd1, 4'd0});
    exp_wr.push_back({4'd2, 4'd0});
    exp_res.push_back(mk(1, 0, 3, 3, 0));
    wr_chk = 1'b1;
    go(0, 0, 0, 3, 0);
    wait_end(0, n);
    wr_chk = 1'b0;
    check("t1_done_cycle", n, 13);
    repeat (3) exp_mv.push_back(2'd0);
    replay("t1_replay", 3);

    // right blocked, up/left skipped by bounds
    clear_maze();
    wall(1, 0);
    wall(1, 1);
    exp_res.push_back(mk(1, 0, 2, 0, 2));
    base = rd_cnt;
    go(0, 0, 0, 0, 2);
    wait_end(0, n);
    check("t2_reads", rd_cnt - base, 5);
    check("t2_done_cycle", n, 21);
    exp_mv.push_back(2'd3);
    exp_mv.push_back(2'd3);
    replay("t2_replay", 2);

    // dead end at (6,5) forces a backtrack
    clear_maze();
    wall(7, 5);
    wall(6, 4);
    wall(6, 6);
    wall(5, 4);
    wall(4, 5);
    wall(4, 6);
    exp_res.push_back(mk(1, 0, 2, 5, 7));
    go(0, 5, 5, 5, 7);
    wait_end(0, n);
    exp_mv.push_back(2'd3);
    exp_mv.push_back(2'd3);
    replay("t3_replay", 2);
    check("t3_deadend_marked", mem_a[6][5], 1'b1);

    // boxed-in start fails, then restart with start == goal
    clear_maze();
    wall(3, 2);
    wall(2, 1);
    wall(1, 2);
    wall(2, 3);
    exp_res.push_back(mk(0, 1, 0, 2, 2));
    base = rd_cnt;
    go(0, 2, 2, 0, 0);
    wait_end(0, n);
    check("t4_reads", rd_cnt - base, 4);
    check("t4_done_low", done_a, 1'b0);
    exp_res.push_back(mk(1, 0, 0, 2, 2));
    go(0, 2, 2, 2, 2);
    wait_end(0, n);
    check("t4_restart_cycle", n, 1);
    check("t4_fail_cleared", fail_a, 1'b0);
    replay("t4_empty_replay", 0);

    // shallow stack overflows on the fifth push
    exp_res_b.push_back(mk(0, 1, 4, 4, 0));
    go(1, 0, 0, 6, 0);
    wait_end(1, n);
    check("t5_len_b", len_b, 3'd4);

    // reset in the middle of a read
    clear_maze();
    go(0, 0, 0, 9, 9);
    k = 0;
    while (!rd_a && k < 100) begin
      @(negedge CLK);
      k++;
    end
    check("t6_rd_seen", rd_a, 1'b1);
    RST = 1'b1;
    @(negedge CLK);
    check("t6_reset_outs",
          {d_in_a, rd_a, wr_a, ax_a, ay_a, x_a, y_a,
           mv_a, mvv_a, len_a, done_a, fail_a}, '0);
    RST = 1'b0;

    // paused replay of a three-move path 00,01,00
    clear_maze();
    wall(2, 1);
    exp_res.push_back(mk(1, 0, 3, 2, 0));
    go(0, 0, 1, 2, 0);
    wait_end(0, n);
    exp_mv.push_back(2'd0);
    exp_mv.push_back(2'd1);
    exp_mv.push_back(2'd0);
    @(posedge CLK);
    #1 run_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK);
      #1 run_a = rp[i];
      @(negedge CLK);
      check("t7_pause_valid", mvv_a, rp[i]);
    end
    @(posedge CLK);
    #1 run_a = 1'b0;
    @(negedge CLK);
    check("t7_after", mvv_a, 1'b0);
    check("t7_done_held", done_a, 1'b1);

    #1;
    check("queues_empty",
          exp_res.size() + exp_res_b.size() +
          exp_mv.size() + exp_wr.size(), 0);
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
